dispensador_troco: RTL and testbench

// Change-payout controller on the consumer side of the newspaper vending FSM's change outputs.

---
 rtl/dispensador_troco.sv | 169 ++++++++++++++++
 tb/tb_dispensador_troco.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_troco.sv
// Change-payout controller: ejects 1-real and 50-cent coins one at a time,
// confirms each on its drop sensor and reports completion or tube-empty errors.
module dispensador_troco #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] rr,
   input  logic [3:0] rdc,
   input  logic       clr,
   input  logic       det_um,
   input  logic       det_cin,
   output logic       ej_um,
   output logic       ej_cin,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [4:0] dispensed
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, EJ_UM, WAIT_UM, GAP_UM, EJ_CIN, WAIT_CIN, DONE, ERR
   } state_t;

   state_t        state_q, route_d;
   logic [3:0]    rem_um_q;
   logic          rem_cin_q, bad_q, pend_q, conf_q;
   logic [CW-1:0] cnt_q;
   logic          ej_um_q, ej_cin_q, busy_q, done_q, err_q;
   logic [4:0]    disp_q;
   logic          win_um, in_win, det_sel, hit, conf_now, pulse_end, tmo, gap_end;

   always_comb begin
      route_d = DONE;
      if (rem_um_q != 4'd0)
         route_d = EJ_UM;
      else if (rem_cin_q)
         route_d = EJ_CIN;
   end

   // The detection window spans both the EJ and WAIT states of a coin type.
   assign win_um    = (state_q == EJ_UM) || (state_q == WAIT_UM);
   assign in_win    = win_um || (state_q == EJ_CIN) || (state_q == WAIT_CIN);
   assign det_sel   = win_um ? det_um : det_cin;
   assign hit       = in_win && det_sel && !conf_q;
   assign conf_now  = conf_q || hit;
   assign pulse_end = (cnt_q == CW'(PULSE_LEN - 1));
   assign tmo       = (cnt_q == CW'(TIMEOUT - 1));
   assign gap_end   = (cnt_q == CW'(GAP_LEN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rem_um_q  <= 4'd0;
         rem_cin_q <= 1'b0;
         bad_q     <= 1'b0;
         pend_q    <= 1'b0;
         conf_q    <= 1'b0;
         cnt_q     <= '0;
         ej_um_q   <= 1'b0;
         ej_cin_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         disp_q    <= 5'd0;
      end else begin
         done_q <= 1'b0;
         if (hit) begin
            conf_q <= 1'b1;
            if (win_um) begin
               rem_um_q <= rem_um_q - 4'd1;
               disp_q   <= disp_q + 5'd2;
            end else begin
               rem_cin_q <= 1'b0;
               disp_q    <= disp_q + 5'd1;
            end
         end
         case (state_q)
            IDLE: begin
               // Request is latched on one edge and routed on the next.
               if (pend_q) begin
                  pend_q <= 1'b0;
                  if (bad_q) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q  <= route_d;
                     busy_q   <= 1'b1;
                     ej_um_q  <= (route_d == EJ_UM);
                     ej_cin_q <= (route_d == EJ_CIN);
                     done_q   <= (route_d == DONE);
                     cnt_q    <= '0;
                     conf_q   <= 1'b0;
                  end
               end else if (start) begin
                  pend_q    <= 1'b1;
                  rem_um_q  <= rr;
                  rem_cin_q <= (rdc == 4'd5);
                  bad_q     <= !((rdc == 4'd0) || (rdc == 4'd5));
                  disp_q    <= 5'd0;
               end
            end
            EJ_UM, EJ_CIN: begin
               cnt_q <= cnt_q + 1'b1;
               if (pulse_end) begin
                  ej_um_q  <= 1'b0;
                  ej_cin_q <= 1'b0;
                  if (conf_now && win_um) begin
                     state_q <= GAP_UM;
                     cnt_q   <= '0;
                  end else if (conf_now) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= win_um ? WAIT_UM : WAIT_CIN;
                  end
               end
            end
            WAIT_UM, WAIT_CIN: begin
               cnt_q <= cnt_q + 1'b1;
               if (conf_now && win_um) begin
                  state_q <= GAP_UM;
                  cnt_q   <= '0;
               end else if (conf_now) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (tmo) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            GAP_UM: begin
               cnt_q <= cnt_q + 1'b1;
               if (gap_end) begin
                  state_q  <= route_d;
                  ej_um_q  <= (route_d == EJ_UM);
                  ej_cin_q <= (route_d == EJ_CIN);
                  done_q   <= (route_d == DONE);
                  cnt_q    <= '0;
                  conf_q   <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            ERR: begin
               if (clr) begin
                  state_q <= IDLE;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ej_um     = ej_um_q;
   assign ej_cin    = ej_cin_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign dispensed = disp_q;
endmodule

// File: tb/tb_dispensador_troco.sv
// Scoreboard bench for dispensador_troco: per-request outcome, paid value,
// coin counts and start-to-response latency derived from the payout rules.
module tb_dispensador_troco;
   localparam int PL = 4, GL = 2, TO = 16;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, clr = 1'b0;
   logic det_um = 1'b0, det_cin = 1'b0;
   logic [3:0] rr = 4'd0, rdc = 4'd0;
   logic ej_um, ej_cin, busy, done, err;
   logic [4:0] dispensed;

   dispensador_troco #(.PULSE_LEN(PL), .GAP_LEN(GL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .rr(rr), .rdc(rdc), .clr(clr),
      .det_um(det_um), .det_cin(det_cin), .ej_um(ej_um), .ej_cin(ej_cin),
      .busy(busy), .done(done), .err(err), .dispensed(dispensed)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_err;
      int disp;
      int n_um;
      int n_cin;
      int lat;
      int t0;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   int pd[16];
   bit pm[16], px[16];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: counts ejector pulses and scores each done/err against the queue.
   initial begin
      int um_len, cin_len, n_um, n_cin;
      logic p_um, p_cin, p_err;
      exp_t e;
      um_len = 0; cin_len = 0; n_um = 0; n_cin = 0;
      p_um = 0; p_cin = 0; p_err = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            um_len = 0; cin_len = 0; n_um = 0; n_cin = 0;
            p_um = 0; p_cin = 0; p_err = 0;
         end else begin
            if (ej_um) begin
               if (!p_um) n_um++;
               um_len++;
            end else if (p_um) begin
               chk("ej_um pulse length", um_len, PL);
               um_len = 0;
            end
            if (ej_cin) begin
               if (!p_cin) n_cin++;
               cin_len++;
            end else if (p_cin) begin
               chk("ej_cin pulse length", cin_len, PL);
               cin_len = 0;
            end
            if (done || (err && !p_err)) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected response: done=%0b err=%0b with no request outstanding", done, err);
               end else begin
                  e = q.pop_front();
                  chk("outcome is error", int'(err), int'(e.is_err));
                  chk("dispensed", int'(dispensed), e.disp);
                  chk("1-real coins ejected", n_um, e.n_um);
                  chk("50-cent coins ejected", n_cin, e.n_cin);
                  chk("start-to-response latency", cyc - e.t0, e.lat);
                  chk("busy at response", int'(busy), e.is_err ? 0 : 1);
               end
               n_um = 0;
               n_cin = 0;
            end
            p_um = ej_um;
            p_cin = ej_cin;
            p_err = err;
         end
      end
   end

   task automatic wait_lvl(input int which, input bit lvl, input int budget, output bit ok);
      logic s;
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         case (which)
            0: s = ej_um;
            1: s = ej_cin;
            default: s = done | err;
         endcase
         if (s == lvl) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait timeout: signal %0d never reached %0b within %0d cycles", which, lvl, budget);
      end
   endtask

   task automatic recover();
      @(posedge clk);
      #1 rst = 1'b0;
      det_um = 0; det_cin = 0; start = 0; clr = 0;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic plan(input int d, input bit m, input bit x);
      for (int i = 0; i < 16; i++) begin
         pd[i] = d;
         pm[i] = m;
         px[i] = x;
      end
   endtask

   task automatic run_txn(input int r, input int d5, input bit noise, input bit bstart);
      exp_t e;
      bit bad, ok, is_um;
      int ncoin;
      bad = !(d5 == 0 || d5 == 5);
      ncoin = bad ? 0 : r + ((d5 == 5) ? 1 : 0);
      // Reference: walk the coin list, summing value and time per coin.
      e.is_err = bad; e.disp = 0; e.n_um = 0; e.n_cin = 0; e.lat = 1;
      for (int i = 0; i < ncoin; i++) begin
         is_um = (i < r);
         if (is_um) e.n_um++; else e.n_cin++;
         if (pm[i]) begin
            e.is_err = 1;
            e.lat += TO;
            break;
         end
         e.lat += ((pd[i] > PL) ? pd[i] : PL) + (is_um ? GL : 0);
         e.disp += is_um ? 2 : 1;
      end
      @(posedge clk);
      #1 rr = 4'(r); rdc = 4'(d5); start = 1'b1;
      e.t0 = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0; rr = 4'($urandom); rdc = 4'($urandom);
      ok = 1;
      for (int i = 0; i < ncoin; i++) begin
         is_um = (i < r);
         wait_lvl(is_um ? 0 : 1, 1'b0, 40, ok);
         if (!ok) break;
         wait_lvl(is_um ? 0 : 1, 1'b1, 40, ok);
         if (!ok) break;
         repeat (pd[i] - 1) @(posedge clk);
         #1;
         if (!pm[i]) begin
            if (is_um) det_um = 1'b1; else det_cin = 1'b1;
         end
         if (noise) begin
            if (is_um) det_cin = 1'b1; else det_um = 1'b1;
         end
         if (bstart) begin
            start = 1'b1; rr = 4'($urandom); rdc = 4'd5;
         end
         repeat ((px[i] && !pm[i]) ? 3 : 1) @(posedge clk);
         #1 det_um = 1'b0; det_cin = 1'b0; start = 1'b0;
         if (pm[i]) break;
      end
      if (ok) wait_lvl(2, 1'b1, 400, ok);
      if (!ok) begin
         recover();
      end else if (err) begin
         @(posedge clk);
         #1 clr = 1'b1;
         @(posedge clk);
         #1 clr = 1'b0;
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      bit ok;
      int r, d5, v;
      #12;
      chk("reset outputs", int'({ej_um, ej_cin, busy, done, err, dispensed}), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      plan(5, 0, 0); run_txn(2, 5, 0, 0);
      plan(5, 0, 0); run_txn(0, 0, 0, 0);
      plan(5, 0, 0); run_txn(1, 3, 0, 0);
      chk("err cleared by clr", int'(err), 0);
      plan(5, 0, 0); pm[1] = 1; run_txn(2, 0, 0, 0);
      plan(1, 0, 1); run_txn(1, 0, 0, 0);
      plan(1, 0, 0); run_txn(15, 5, 0, 0);
      plan(8, 0, 0); run_txn(0, 5, 1, 1);
      plan(16, 0, 0); run_txn(1, 5, 0, 0);

      for (int t = 0; t < 30; t++) begin
         r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         if ($urandom_range(0, 9) < 7) begin
            d5 = $urandom_range(0, 1) ? 5 : 0;
         end else begin
            v = $urandom_range(1, 14);
            d5 = (v >= 5) ? v + 1 : v;
         end
         for (int i = 0; i < 16; i++) begin
            pd[i] = $urandom_range(1, 16);
            pm[i] = ($urandom_range(0, 9) == 0);
            px[i] = (pd[i] <= 2) && ($urandom_range(0, 1) == 1);
         end
         run_txn(r, d5, $urandom_range(0, 1), $urandom_range(0, 1));
      end

      // Start while busy, then reset mid-pulse: the request is abandoned.
      @(posedge clk);
      #1 rr = 4'd3; rdc = 4'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_lvl(0, 1'b1, 40, ok);
      #1 start = 1'b1; rr = 4'd1;
      @(posedge clk);
      #3 start = 1'b0; rst = 1'b0;
      #1;
      chk("outputs during async reset", int'({ej_um, ej_cin, busy, done, err, dispensed}), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      plan(5, 0, 0); run_txn(1, 5, 0, 0);
      chk("scoreboard drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end
endmodule
